hwacc_path_sched: RTL
=====================

// Module: hwacc_path_sched
// PURPOSE
//  Per-packet scheduler that drives the HW accelerator's path_sel, key, inside_payload and data_count sidebands.
//  Watches the word stream entering the accelerator and frames packets from the ctrl word.
//  Latches path/key once per packet so that a configuration change never lands mid-packet.
//  Stalls upstream for DRAIN_CYCLES (the accelerator pipeline depth) before a packet that switches path.
// PARAMETERS
//  CTRL_WIDTH    8      ctrl bus width; SOP marker = all ones
//  HDR_WORDS     3      header words per packet, SOP word included (>=1)
//  DRAIN_CYCLES  7      idle cycles forced between packets on different paths (>=1)
// PORTS
//  i_clock         in   1           single clock
//  i_reset         in   1           synchronous, active-high reset
//  cfg_path_sel    in   2           requested path: 00 ALU, 01 encrypt, 10 decrypt, 11 -> treated as 00
//  cfg_key         in   80          requested key
//  s_ctrl          in   CTRL_WIDTH  ctrl of the word presented to the accelerator
//  s_wr            in   1           word valid (write strobe into the accelerator)
//  acc_rdy         in   1           in_rdy from the accelerator
//  s_rdy           out  1           ready to upstream = acc_rdy & ~stall
//  path_sel        out  2           to accelerator; registered
//  key             out  80          to accelerator; registered
//  inside_payload  out  1           to accelerator; registered
//  data_count      out  16          payload words accepted in current packet; registered
//  err_framing     out  1           sticky framing-error flag; cleared only by reset
// BEHAVIOUR
//  Reset values: path_sel=00, key=0, inside_payload=0, data_count=0, err_framing=0, state=IDLE, stall=0.
//  Word accepted ("acc") = s_wr & s_rdy; only accepted words advance state.
//  SOP = acc & s_ctrl=={CTRL_WIDTH{1}}; EOP = acc & s_ctrl!=0 & not SOP.
//  FSM states:
//   IDLE:    on SOP: path_sel<=cfg_path_sel (11->00), key<=cfg_key, hdr_cnt<=1, data_count<=0.
//            Next state is PAYLOAD if HDR_WORDS==1, else HDR. Non-SOP accepted word: err_framing<=1, ignored.
//   HDR:     each acc increments hdr_cnt; when hdr_cnt reaches HDR_WORDS -> PAYLOAD, inside_payload<=1.
//            EOP in HDR (short packet): err_framing<=1, go to END.
//   PAYLOAD: each acc increments data_count (saturates at 16'hFFFF), including the EOP word.
//            EOP -> END, inside_payload<=0 on the same edge.
//            SOP in PAYLOAD: err_framing<=1, treated as EOP of the current packet; the word itself is dropped from framing.
//   END:     one cycle; if cfg_path_sel (11->00) != path_sel -> DRAIN with drain_cnt<=DRAIN_CYCLES, stall<=1; else IDLE.
//   DRAIN:   stall=1 (s_rdy=0); drain_cnt decrements each cycle; at 1 -> IDLE, stall<=0.
//  Cycle timing: sideband outputs update on the clock edge that accepts the triggering word and are visible next cycle.
//  The SOP word itself is forwarded under the previous path_sel (header words bypass the crypto path).
//  path_sel and key never change outside IDLE, even if cfg_* changes mid-packet.
//  s_rdy is combinational from acc_rdy and the registered stall; no combinational path from s_wr.
//  s_wr while s_rdy=0: not accepted, no state change, no error.
//  Reset asserted mid-packet or mid-drain: all state to reset values next edge; the partial packet is abandoned.
//  Back-to-back: SOP may be accepted the cycle after END if no drain is required (two-cycle minimum gap between EOP and SOP).
// CONFIGURATION
//  HWACC_PKT_STATS_EN defined: adds outputs stat_pkts_alu, stat_pkts_enc, stat_pkts_dec (32 bits each, wrap at 2^32).
//   Each counter increments at END for the path just used; reset to 0.
//  HWACC_PKT_STATS_EN undefined: counters and ports absent; all other behaviour identical.
// TESTING
//  Reset, then cfg_path_sel=01, HDR_WORDS=3: SOP + 2 header + 4 payload (last ctrl=8'h80), acc_rdy=1
//   -> path_sel=01 one cycle after SOP; inside_payload high for 4 cycles; data_count ends at 4; err_framing=0.
//  Change cfg_path_sel 01->10 and cfg_key mid-payload -> path_sel/key unchanged until the next SOP;
//   after EOP: END, then s_rdy=0 for exactly 7 cycles, then IDLE; next SOP latches 10.
//  Two packets with the same path 01 -> no DRAIN; second SOP accepted 2 cycles after first EOP.
//  EOP (ctrl=8'h01) on the 2nd header word -> err_framing=1 (sticky), inside_payload never rises, FSM returns to IDLE.
//  acc_rdy toggling 1,0 during payload with s_wr=1 held -> data_count counts only cycles with acc_rdy=1.
//  i_reset pulsed during DRAIN -> next cycle s_rdy=acc_rdy, path_sel=00, state IDLE;
//   with HWACC_PKT_STATS_EN, counters read 0.

Source files
------------

// File: rtl/hwacc_path_sched.sv
// Per-packet path/key scheduler for the HW accelerator sidebands, with drain stall on path switch.
// Optional per-path packet counters when HWACC_PKT_STATS_EN is defined.
module hwacc_path_sched #(
    parameter int CTRL_WIDTH   = 8,
    parameter int HDR_WORDS    = 3,
    parameter int DRAIN_CYCLES = 7
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [1:0]            cfg_path_sel,
    input  logic [79:0]           cfg_key,
    input  logic [CTRL_WIDTH-1:0] s_ctrl,
    input  logic                  s_wr,
    input  logic                  acc_rdy,
    output logic                  s_rdy,
    output logic [1:0]            path_sel,
    output logic [79:0]           key,
    output logic                  inside_payload,
    output logic [15:0]           data_count,
`ifdef HWACC_PKT_STATS_EN
    output logic [31:0]           stat_pkts_alu,
    output logic [31:0]           stat_pkts_enc,
    output logic [31:0]           stat_pkts_dec,
`endif
    output logic                  err_framing
);

    // state     | meaning
    // S_IDLE    | waiting for SOP; path/key may be relatched here only
    // S_HDR     | counting header words (SOP included)
    // S_PAYLOAD | counting payload words until EOP
    // S_END     | one cycle; decide whether the next packet needs a drain
    // S_DRAIN   | upstream stalled while the accelerator pipeline empties
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_END, S_DRAIN} state_t;

    localparam int HCW = $clog2(HDR_WORDS + 1);
    localparam int DCW = $clog2(DRAIN_CYCLES + 1);

    state_t          state_q;
    logic            stall_q;
    logic [1:0]      path_q;
    logic [79:0]     key_q;
    logic            inpay_q;
    logic [15:0]     dcnt_q;
    logic            err_q;
    logic [HCW-1:0]  hdr_cnt_q;
    logic [DCW-1:0]  drain_cnt_q;

    logic            acc, sop, eop;
    logic [1:0]      req_path;
    logic [HCW-1:0]  hdr_cnt_d;
    logic [15:0]     dcnt_d;

    assign s_rdy     = acc_rdy & ~stall_q;
    assign acc       = s_wr & s_rdy;
    assign sop       = acc & (s_ctrl == {CTRL_WIDTH{1'b1}});
    assign eop       = acc & (s_ctrl != '0) & ~sop;
    assign req_path  = (cfg_path_sel == 2'b11) ? 2'b00 : cfg_path_sel;
    assign hdr_cnt_d = hdr_cnt_q + 1'b1;
    assign dcnt_d    = (dcnt_q == 16'hFFFF) ? dcnt_q : dcnt_q + 16'd1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            stall_q     <= 1'b0;
            path_q      <= 2'b00;
            key_q       <= '0;
            inpay_q     <= 1'b0;
            dcnt_q      <= '0;
            err_q       <= 1'b0;
            hdr_cnt_q   <= '0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sop) begin
                        path_q    <= req_path;
                        key_q     <= cfg_key;
                        hdr_cnt_q <= HCW'(1);
                        dcnt_q    <= '0;
                        if (HDR_WORDS == 1) begin
                            state_q <= S_PAYLOAD;
                            inpay_q <= 1'b1;
                        end else begin
                            state_q <= S_HDR;
                        end
                    end else if (acc) begin
                        err_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (eop) begin
                        err_q   <= 1'b1;
                        state_q <= S_END;
                    end else if (acc) begin
                        hdr_cnt_q <= hdr_cnt_d;
                        if (hdr_cnt_d == HCW'(HDR_WORDS)) begin
                            state_q <= S_PAYLOAD;
                            inpay_q <= 1'b1;
                        end
                    end
                end
                S_PAYLOAD: begin
                    // A stray SOP closes the packet but is not counted as payload.
                    if (sop) begin
                        err_q   <= 1'b1;
                        inpay_q <= 1'b0;
                        state_q <= S_END;
                    end else if (acc) begin
                        dcnt_q <= dcnt_d;
                        if (eop) begin
                            inpay_q <= 1'b0;
                            state_q <= S_END;
                        end
                    end
                end
                S_END: begin
                    if (req_path != path_q) begin
                        state_q     <= S_DRAIN;
                        drain_cnt_q <= DCW'(DRAIN_CYCLES);
                        stall_q     <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DCW'(1)) begin
                        state_q <= S_IDLE;
                        stall_q <= 1'b0;
                    end
                    drain_cnt_q <= drain_cnt_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign path_sel       = path_q;
    assign key            = key_q;
    assign inside_payload = inpay_q;
    assign data_count     = dcnt_q;
    assign err_framing    = err_q;

`ifdef HWACC_PKT_STATS_EN
    logic [31:0] st_alu_q, st_enc_q, st_dec_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            st_alu_q <= '0;
            st_enc_q <= '0;
            st_dec_q <= '0;
        end else if (state_q == S_END) begin
            case (path_q)
                2'b01:   st_enc_q <= st_enc_q + 32'd1;
                2'b10:   st_dec_q <= st_dec_q + 32'd1;
                default: st_alu_q <= st_alu_q + 32'd1;
            endcase
        end
    end

    assign stat_pkts_alu = st_alu_q;
    assign stat_pkts_enc = st_enc_q;
    assign stat_pkts_dec = st_dec_q;
`endif

endmodule
